// File: rtl/spi_exchange_ctrl_pkg.sv
// Shared definitions for the SPI ping-pong exchange sequencer: FSM encoding
// and the width derivations used by the top and the byte counter.
package spi_exchange_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RECEIVE = 2'd1,
        ST_PENDING = 2'd2
    } state_t;

    function automatic int bytes_per_word(input int data_width, input int spi_data_width);
        return data_width / spi_data_width;
    endfunction

    // Address width for a given depth, never narrower than one bit.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/spi_exchange_ctrl_byte_counter.sv
// SPI byte strobe generation and word/byte addressing within one frame.
// Bytes beyond a complete frame are flagged instead of written.
module spi_byte_counter
    import spi_exchange_ctrl_pkg::*;
#(
    parameter int BYTES    = 4,
    parameter int BUF_SIZE = 10
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          spi_ready,
    input  logic                          clear,
    input  logic                          active,
    output logic [addr_width(BUF_SIZE)-1:0] word_addr,
    output logic [addr_width(BYTES)-1:0]    byte_sel,
    output logic                          byte_we,
    output logic                          complete,
    output logic                          excess
);

    localparam int WA_W = addr_width(BUF_SIZE);
    localparam int BS_W = addr_width(BYTES);

    logic            ready_reg;
    logic            pend_reg;
    logic            complete_reg;
    logic [WA_W-1:0] word_addr_reg;
    logic [BS_W-1:0] byte_sel_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_reg <= 1'b0;
            pend_reg  <= 1'b0;
        end else begin
            ready_reg <= spi_ready;
            pend_reg  <= spi_ready & ~ready_reg;
        end
    end

    assign byte_we  = pend_reg & active & ~complete_reg;
    assign excess   = pend_reg & active & complete_reg;
    assign complete = complete_reg;

    // The strobe is issued with the current address; the address advances
    // on the same clock edge that ends the strobe cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_addr_reg <= '0;
            byte_sel_reg  <= '0;
            complete_reg  <= 1'b0;
        end else if (clear) begin
            word_addr_reg <= '0;
            byte_sel_reg  <= '0;
            complete_reg  <= 1'b0;
        end else if (byte_we) begin
            if (byte_sel_reg == BS_W'(BYTES - 1)) begin
                if (word_addr_reg == WA_W'(BUF_SIZE - 1)) begin
                    complete_reg <= 1'b1;
                end else begin
                    word_addr_reg <= word_addr_reg + 1'b1;
                    byte_sel_reg  <= '0;
                end
            end else begin
                byte_sel_reg <= byte_sel_reg + 1'b1;
            end
        end
    end

    assign word_addr = word_addr_reg;
    assign byte_sel  = byte_sel_reg;

endmodule

// File: rtl/spi_exchange_ctrl.sv
// Ping-pong bank sequencer between an SPI slave and a processing unit.
// Banks swap only once a full SPI frame is held and the processor released its bank.
module spi_exchange_ctrl
    import spi_exchange_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int SPI_DATA_WIDTH = 8,
    parameter int BUF_SIZE       = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic spi_cs,
    input  logic spi_ready,
    input  logic pu_wr,
    input  logic pu_oe,
    input  logic pu_release,
    output logic bank_sel,
    output logic [addr_width(BUF_SIZE)-1:0] spi_word_addr,
    output logic [addr_width(bytes_per_word(DATA_WIDTH, SPI_DATA_WIDTH))-1:0] spi_byte_sel,
    output logic spi_byte_we,
    output logic [addr_width(BUF_SIZE)-1:0] pu_addr,
    output logic pu_full,
    output logic swap,
    output logic overrun,
    output logic frame_err
);

    localparam int BYTES = bytes_per_word(DATA_WIDTH, SPI_DATA_WIDTH);
    localparam int WA_W  = addr_width(BUF_SIZE);

    state_t          state_reg, state_next;
    logic            cs_reg, strobe_reg;
    logic            released_reg, held_reg, swap_reg, bank_reg;
    logic            overrun_reg, frame_err_reg, pu_full_reg;
    logic [WA_W-1:0] pu_addr_reg;

    logic cs_rise, cs_fall, release_seen;
    logic start, swap_next, set_held, set_overrun, set_err;
    logic frame_complete, excess_byte;

    assign cs_rise      = spi_cs & ~cs_reg;
    assign cs_fall      = ~spi_cs & cs_reg;
    assign release_seen = released_reg | pu_release;

    spi_byte_counter #(
        .BYTES    (BYTES),
        .BUF_SIZE (BUF_SIZE)
    ) u_byte_counter (
        .clk       (clk),
        .rst       (rst),
        .spi_ready (spi_ready),
        .clear     (start),
        .active    (state_reg == ST_RECEIVE),
        .word_addr (spi_word_addr),
        .byte_sel  (spi_byte_sel),
        .byte_we   (spi_byte_we),
        .complete  (frame_complete),
        .excess    (excess_byte)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= ST_IDLE;
        else      state_reg <= state_next;
    end

    always_comb begin
        state_next  = state_reg;
        start       = 1'b0;
        swap_next   = 1'b0;
        set_held    = 1'b0;
        set_overrun = 1'b0;
        set_err     = excess_byte;
        case (state_reg)
            ST_IDLE: begin
                if (cs_rise) begin
                    start       = 1'b1;
                    state_next  = ST_RECEIVE;
                    set_overrun = held_reg;
                end
            end
            ST_RECEIVE: begin
                if (cs_fall) begin
                    if (frame_complete) begin
                        state_next = ST_PENDING;
                        set_held   = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                        set_err    = 1'b1;
                    end
                end
            end
            ST_PENDING: begin
                // A coinciding new frame is not lost: it starts after the swap.
                if (release_seen) begin
                    swap_next  = 1'b1;
                    state_next = cs_rise ? ST_RECEIVE : ST_IDLE;
                    start      = cs_rise;
                end else if (cs_rise) begin
                    start       = 1'b1;
                    state_next  = ST_RECEIVE;
                    set_overrun = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cs_reg        <= 1'b0;
            strobe_reg    <= 1'b0;
            released_reg  <= 1'b0;
            held_reg      <= 1'b0;
            swap_reg      <= 1'b0;
            bank_reg      <= 1'b0;
            overrun_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
            pu_full_reg   <= 1'b0;
            pu_addr_reg   <= '0;
        end else begin
            cs_reg        <= spi_cs;
            strobe_reg    <= pu_wr | pu_oe;
            swap_reg      <= swap_next;
            overrun_reg   <= overrun_reg | set_overrun;
            frame_err_reg <= frame_err_reg | set_err;
            if (swap_next)     held_reg <= 1'b0;
            else if (set_held) held_reg <= 1'b1;
            // A release landing in the swap cycle is absorbed by that swap.
            if (swap_reg) begin
                released_reg <= 1'b0;
                bank_reg     <= ~bank_reg;
                pu_addr_reg  <= '0;
                pu_full_reg  <= 1'b0;
            end else begin
                released_reg <= released_reg | pu_release;
                if (strobe_reg && !(pu_wr | pu_oe) && !pu_full_reg) begin
                    if (pu_addr_reg == WA_W'(BUF_SIZE - 1)) pu_full_reg <= 1'b1;
                    else                                   pu_addr_reg <= pu_addr_reg + 1'b1;
                end
            end
        end
    end

    assign bank_sel  = bank_reg;
    assign swap      = swap_reg;
    assign overrun   = overrun_reg;
    assign frame_err = frame_err_reg;
    assign pu_addr   = pu_addr_reg;
    assign pu_full   = pu_full_reg;

endmodule
